mm_burst_bridge: RTL

MM_BURST_BRIDGE -- requirements
Module: mm_burst_bridge

---
 rtl/mm_burst_bridge.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mm_burst_bridge.sv
// Burst bridge between a command/write/read streaming interface and a simple
// accelerator memory map. Writes are registered one beat per cycle; reads return through a small FIFO.
module mm_burst_bridge #(
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LEN_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_last,
   output logic              mm_write_enable,
   output logic [ADDR_W-1:0] mm_write_addr,
   output logic [DATA_W-1:0] mm_write_data,
   output logic [ADDR_W-1:0] mm_read_addr,
   input  logic [DATA_W-1:0] mm_read_data,
   input  logic              mm_busy,
   output logic              done
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [LEN_W:0] BEAT_ONE = (LEN_W+1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN
   } state_e;

   // Reset asserts asynchronously; release is delayed two edges so no flop leaves reset on a metastable edge.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   state_e              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W:0]      beats_q;
   logic [LEN_W:0]      pops_q;
   logic                inflight_q;
   logic                we_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [ADDR_W-1:0]   raddr_q;
   logic                done_q;

   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;

   logic                wr_accept;
   logic                rd_issue;
   logic                push;
   logic                pop;
   logic                last_pop;
   logic [CNT_W:0]      occ;
   logic [LEN_W:0]      beats_init;

   assign beats_init  = {1'b0, cmd_len} + BEAT_ONE;
   assign cmd_ready   = (state_q == IDLE);
   assign wdata_ready = (state_q == WRITE) && !mm_busy && (beats_q != '0);
   assign wr_accept   = wdata_valid && wdata_ready;

   // A read in flight already owns a FIFO slot, so it counts against capacity.
   assign occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign rd_issue = (state_q == READ) && !mm_busy && (beats_q != '0) &&
                     (occ < (CNT_W+1)'(FIFO_DEPTH));

   assign push        = inflight_q;
   assign rdata_valid = (count_q != '0);
   assign pop         = rdata_valid && rdata_ready;
   assign rdata       = rdata_valid ? mem_q[rd_ptr_q] : '0;
   assign rdata_last  = rdata_valid && (pops_q == BEAT_ONE);
   assign last_pop    = pop && (pops_q == BEAT_ONE);

   assign mm_write_enable = we_q;
   assign mm_write_addr   = waddr_q;
   assign mm_write_data   = wdata_q;
   assign mm_read_addr    = raddr_q;
   assign done            = done_q;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         beats_q    <= '0;
         pops_q     <= '0;
         inflight_q <= 1'b0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         raddr_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         inflight_q <= rd_issue;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  beats_q <= beats_init;
                  pops_q  <= cmd_write ? '0 : beats_init;
                  state_q <= cmd_write ? WRITE : READ;
               end
            end
            WRITE: begin
               if (wr_accept) begin
                  we_q    <= 1'b1;
                  waddr_q <= addr_q;
                  wdata_q <= wdata;
                  addr_q  <= addr_q + ADDR_W'(1);
                  beats_q <= beats_q - BEAT_ONE;
                  if (beats_q == BEAT_ONE) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            READ: begin
               if (rd_issue) begin
                  raddr_q <= addr_q;
                  addr_q  <= addr_q + ADDR_W'(1);
                  beats_q <= beats_q - BEAT_ONE;
                  if (beats_q == BEAT_ONE) begin
                     state_q <= DRAIN;
                  end
               end
               if (pop) begin
                  pops_q <= pops_q - BEAT_ONE;
               end
            end
            DRAIN: begin
               if (pop) begin
                  pops_q <= pops_q - BEAT_ONE;
               end
               if (last_pop && !inflight_q) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= mm_read_data;
      end
   end

endmodule
